rng_ehr_fetch: RTL and testbench

RNG_EHR_FETCH -- requirements
Module: rng_ehr_fetch

---
 rtl/rng_ehr_fetch_if.sv | 27 ++
 rtl/rng_ehr_fetch.sv | 194 +++++++++++++++++++
 tb/tb_rng_ehr_fetch.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_ehr_fetch_if.sv
// rtl/rng_ehr_fetch_if.sv - APB register bus between the EHR fetch master and the RNG register slave
//
// Signals:
//   m_psel    master -> slave  select; high for both phases of a transfer
//   m_penable master -> slave  high in the access phase only
//   m_pwrite  master -> slave  1 = write
//   m_paddr   master -> slave  12-bit register offset
//   m_pwdata  master -> slave  write data
//   m_prdata  slave -> master  read data, valid in the access phase
interface rng_ehr_fetch_if;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [11:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata;

    modport master (
        output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
        input  m_prdata
    );

    modport slave (
        input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
        output m_prdata
    );
endinterface

// File: rtl/rng_ehr_fetch.sv
// rtl/rng_ehr_fetch.sv - polls the RNG ISR, fetches one 128-bit EHR sample and clears the interrupt
//
// Ports:
//   rng_clk    clock, rising edge
//   rst_n      synchronous active-low reset
//   fetch_req  level request for one sample
//   busy       high whenever the FSM is not in IDLE
//   apb        APB master toward the RNG register block
//   out_data   captured sample, EHR_DATA0 in [31:0] .. EHR_DATA3 in [127:96]
//   out_valid  sample valid, held until out_ready
//   out_ready  consumer accept, only looked at while presenting a sample
//   err_valid  one-cycle error pulse
//   err_code   {timeout, vn_err, crngt_err, autocorr_err}, zero unless err_valid
module rng_ehr_fetch #(
    parameter logic [11:0] ADDR_ISR  = 12'h104,
    parameter logic [11:0] ADDR_ICR  = 12'h108,
    parameter logic [11:0] ADDR_EHR0 = 12'h114,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 255
) (
    input  logic                   rng_clk,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    output logic                   busy,
    rng_ehr_fetch_if.master        apb,
    output logic [127:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err_valid,
    output logic [3:0]             err_code
);

    typedef enum logic [3:0] {
        IDLE, POLL_S, POLL_A, GAP, RD_S, RD_A, CLR_S, CLR_A, OUT
    } state_t;

    localparam logic [3:0] GAP_LAST  = (POLL_GAP == 0) ? 4'd0 : 4'(POLL_GAP - 1);
    localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLLS);

    state_t      state;
    logic [7:0]  poll_cnt;
    logic [3:0]  gap_cnt;
    logic [1:0]  idx;
    logic [3:0]  isr;

    logic [3:0]  rd_isr;
    logic [7:0]  poll_next;
    logic [1:0]  idx_inc;
    logic [11:0] ehr_addr_next;

    assign rd_isr        = apb.m_prdata[3:0];
    // Saturating so a huge MAX_POLLS can never wrap the count back to a small value.
    assign poll_next     = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
    assign idx_inc       = idx + 2'd1;
    assign ehr_addr_next = ADDR_EHR0 + {8'd0, idx_inc, 2'b00};

    always_ff @(posedge rng_clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            poll_cnt      <= 8'd0;
            gap_cnt       <= 4'd0;
            idx           <= 2'd0;
            isr           <= 4'd0;
            busy          <= 1'b0;
            out_data      <= 128'h0;
            out_valid     <= 1'b0;
            err_valid     <= 1'b0;
            err_code      <= 4'd0;
            apb.m_psel    <= 1'b0;
            apb.m_penable <= 1'b0;
            apb.m_pwrite  <= 1'b0;
            apb.m_paddr   <= 12'h0;
            apb.m_pwdata  <= 32'h0;
        end else begin
            // Bus is idle and the error pulse drops unless a branch below says otherwise.
            apb.m_psel    <= 1'b0;
            apb.m_penable <= 1'b0;
            apb.m_pwrite  <= 1'b0;
            apb.m_paddr   <= 12'h0;
            apb.m_pwdata  <= 32'h0;
            err_valid     <= 1'b0;
            err_code      <= 4'd0;

            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        state       <= POLL_S;
                        busy        <= 1'b1;
                        poll_cnt    <= 8'd0;
                        apb.m_psel  <= 1'b1;
                        apb.m_paddr <= ADDR_ISR;
                    end
                end

                // Every setup phase becomes its access phase with the same address/data.
                POLL_S, RD_S, CLR_S: begin
                    apb.m_psel    <= 1'b1;
                    apb.m_penable <= 1'b1;
                    apb.m_pwrite  <= apb.m_pwrite;
                    apb.m_paddr   <= apb.m_paddr;
                    apb.m_pwdata  <= apb.m_pwdata;
                    state <= (state == POLL_S) ? POLL_A :
                             (state == RD_S)   ? RD_A   : CLR_A;
                end

                POLL_A: begin
                    isr <= rd_isr;
                    if (rd_isr[3:1] != 3'b000) begin
                        // Health-test failure: acknowledge exactly the bits seen.
                        state        <= CLR_S;
                        apb.m_psel   <= 1'b1;
                        apb.m_pwrite <= 1'b1;
                        apb.m_paddr  <= ADDR_ICR;
                        apb.m_pwdata <= {28'b0, rd_isr};
                    end else if (rd_isr[0]) begin
                        state       <= RD_S;
                        idx         <= 2'd0;
                        apb.m_psel  <= 1'b1;
                        apb.m_paddr <= ADDR_EHR0;
                    end else begin
                        poll_cnt <= poll_next;
                        if (poll_next == POLL_LIMIT) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            err_valid <= 1'b1;
                            err_code  <= 4'b1000;
                        end else if (POLL_GAP == 0) begin
                            state       <= POLL_S;
                            apb.m_psel  <= 1'b1;
                            apb.m_paddr <= ADDR_ISR;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 4'd0;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= POLL_S;
                        apb.m_psel  <= 1'b1;
                        apb.m_paddr <= ADDR_ISR;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                RD_A: begin
                    out_data[{idx, 5'd0} +: 32] <= apb.m_prdata;
                    if (idx == 2'd3) begin
                        // On the data path isr is 4'b0001, so this writes 32'h1.
                        state        <= CLR_S;
                        apb.m_psel   <= 1'b1;
                        apb.m_pwrite <= 1'b1;
                        apb.m_paddr  <= ADDR_ICR;
                        apb.m_pwdata <= {28'b0, isr};
                    end else begin
                        state       <= RD_S;
                        idx         <= idx_inc;
                        apb.m_psel  <= 1'b1;
                        apb.m_paddr <= ehr_addr_next;
                    end
                end

                CLR_A: begin
                    if (isr[3:1] != 3'b000) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        err_valid <= 1'b1;
                        err_code  <= {1'b0, isr[3:1]};
                    end else begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_ehr_fetch.sv
// tb/tb_rng_ehr_fetch.sv - randomized self-checking bench for rng_ehr_fetch
module tb_rng_ehr_fetch;

    localparam logic [11:0] A_ISR = 12'h104;
    localparam logic [11:0] A_ICR = 12'h108;
    localparam logic [11:0] A_EHR = 12'h114;
    localparam int GAP  = 4;
    localparam int MAXK = 128;

    logic rng_clk = 1'b0;
    always #5 rng_clk = ~rng_clk;

    logic         rst_n = 1'b0;
    logic         fetch_req = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy, out_valid, err_valid;
    logic [127:0] out_data;
    logic [3:0]   err_code;

    rng_ehr_fetch_if apb ();

    rng_ehr_fetch dut (
        .rng_clk   (rng_clk),
        .rst_n     (rst_n),
        .fetch_req (fetch_req),
        .busy      (busy),
        .apb       (apb.master),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_valid (err_valid),
        .err_code  (err_code)
    );

    // Second instance with a short poll limit for the timeout path.
    logic         fetch_req_t = 1'b0;
    logic         busy_t, out_valid_t, err_valid_t;
    logic [127:0] out_data_t;
    logic [3:0]   err_code_t;

    rng_ehr_fetch_if apb_t ();

    rng_ehr_fetch #(.MAX_POLLS(3)) dut_t (
        .rng_clk   (rng_clk),
        .rst_n     (rst_n),
        .fetch_req (fetch_req_t),
        .busy      (busy_t),
        .apb       (apb_t.master),
        .out_data  (out_data_t),
        .out_valid (out_valid_t),
        .out_ready (1'b0),
        .err_valid (err_valid_t),
        .err_code  (err_code_t)
    );

    always_comb apb_t.m_prdata = 32'hFFFF_FFF0;

    int checks = 0;
    int errors = 0;

    // Register slave: ISR answers come from a per-fetch script, EHR words from ehr_w.
    logic [31:0] isr_seq [0:15];
    logic [31:0] ehr_w   [0:3];
    int isr_cnt  = 0;
    int isr_base = 0;
    int pi;

    always @(posedge rng_clk)
        if (apb.m_psel && apb.m_penable && !apb.m_pwrite && apb.m_paddr == A_ISR)
            isr_cnt <= isr_cnt + 1;

    always_comb begin
        pi = isr_cnt - isr_base;
        if (pi > 15) pi = 15;
        if (pi < 0)  pi = 0;
        apb.m_prdata = 32'hDEAD_BEEF;
        if (apb.m_psel && apb.m_penable && !apb.m_pwrite) begin
            if (apb.m_paddr == A_ISR)
                apb.m_prdata = isr_seq[pi];
            else if (apb.m_paddr >= A_EHR && apb.m_paddr <= A_EHR + 12'd12)
                apb.m_prdata = ehr_w[2'((apb.m_paddr - A_EHR) >> 2)];
        end
    end

    // Expected per-cycle outputs, index k = cycles after the cycle fetch_req is sampled.
    bit          e_sel [0:MAXK-1];
    bit          e_en  [0:MAXK-1];
    bit          e_wr  [0:MAXK-1];
    logic [11:0] e_ad  [0:MAXK-1];
    logic [31:0] e_wd  [0:MAXK-1];
    bit          e_busy[0:MAXK-1];
    bit          e_ov  [0:MAXK-1];
    bit          e_ev  [0:MAXK-1];
    logic [3:0]  e_ec  [0:MAXK-1];
    logic [127:0] e_data;
    int end_k, t_out;

    // Observations from the latest fetch, used by the literal checks.
    int first_ov, first_err, n_isr, n_ehr, ov_cycles;
    int isr_k [0:15];
    logic [31:0]  icr_wd;
    logic [3:0]   seen_code;
    logic [127:0] cap_data;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [53:0] pk(bit s, bit e, bit w, logic [11:0] a, logic [31:0] d,
                                       bit b, bit ov, bit ev, logic [3:0] ec);
        return {s, e, w, a, d, b, ov, ev, ec};
    endfunction

    task automatic add_xfer(input int s, input logic [11:0] a, input bit w, input logic [31:0] d);
        for (int j = 0; j < 2; j++) begin
            e_sel[s+j] = 1'b1;
            e_en[s+j]  = (j == 1);
            e_wr[s+j]  = w;
            e_ad[s+j]  = a;
            e_wd[s+j]  = d;
        end
    endtask

    // Timeline from the protocol rules: 2-cycle transfers, GAP idle cycles between
    // empty polls, four EHR reads, one ICR write, then the hand-off or error pulse.
    task automatic build_model(input int nz, input logic [3:0] nib, input int d);
        int t;
        for (int k = 0; k < MAXK; k++) begin
            e_sel[k] = 0; e_en[k] = 0; e_wr[k] = 0; e_ad[k] = 0; e_wd[k] = 0;
            e_busy[k] = 0; e_ov[k] = 0; e_ev[k] = 0; e_ec[k] = 0;
        end
        t = 1;
        for (int p = 0; p <= nz; p++) begin
            add_xfer(t, A_ISR, 1'b0, 32'h0);
            t += 2;
            if (p < nz) t += GAP;
        end
        if (nib[3:1] != 3'b000) begin
            add_xfer(t, A_ICR, 1'b1, {28'h0, nib});
            t += 2;
            e_ev[t] = 1;
            e_ec[t] = {1'b0, nib[3:1]};
            end_k = t;
            t_out = 1000;
        end else begin
            for (int i = 0; i < 4; i++) add_xfer(t + 2*i, A_EHR + 12'(4*i), 1'b0, 32'h0);
            t += 8;
            add_xfer(t, A_ICR, 1'b1, 32'h1);
            t += 2;
            t_out = t;
            for (int k = t; k <= t + d; k++) e_ov[k] = 1;
            end_k = t + d + 1;
        end
        for (int k = 1; k < end_k; k++) e_busy[k] = 1;
        e_data = {ehr_w[3], ehr_w[2], ehr_w[1], ehr_w[0]};
    endtask

    // Called at a falling edge; that cycle is k=0 (fetch_req is sampled at its end).
    task automatic run_scn(input int nz, input logic [3:0] last, input int d,
                           input bit chain, input int rst_k, input bit plain);
        logic [31:0] r;
        logic [53:0] got, exp;
        for (int i = 0; i < 16; i++) begin
            r = plain ? 32'h0 : $urandom;
            isr_seq[i] = {r[31:4], (i < nz) ? 4'h0 : last};
        end
        for (int i = 0; i < 4; i++) ehr_w[i] = plain ? 32'hA0 + 32'(i) : $urandom;
        isr_base = isr_cnt;
        build_model(nz, last, d);
        first_ov = -1; first_err = -1; n_isr = 0; n_ehr = 0; ov_cycles = 0;
        icr_wd = 32'hFFFF_FFFF; seen_code = 4'hF; cap_data = 128'h0;
        fetch_req = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        for (int k = 1; k <= end_k; k++) begin
            @(negedge rng_clk);
            got = pk(apb.m_psel, apb.m_penable, apb.m_pwrite, apb.m_paddr, apb.m_pwdata,
                     busy, out_valid, err_valid, err_code);
            exp = pk(e_sel[k], e_en[k], e_wr[k], e_ad[k], e_wd[k],
                     e_busy[k], e_ov[k], e_ev[k], e_ec[k]);
            chk($sformatf("cycle k=%0d", k), got, exp);
            if (e_ov[k]) chk($sformatf("out_data k=%0d", k), out_data, e_data);
            if (apb.m_psel && !apb.m_penable && !apb.m_pwrite && apb.m_paddr == A_ISR) begin
                if (n_isr < 16) isr_k[n_isr] = k;
                n_isr++;
            end
            if (apb.m_psel && !apb.m_penable && !apb.m_pwrite && apb.m_paddr != A_ISR) n_ehr++;
            if (apb.m_psel && apb.m_penable && apb.m_pwrite && apb.m_paddr == A_ICR) icr_wd = apb.m_pwdata;
            if (out_valid) begin
                ov_cycles++;
                if (first_ov < 0) begin first_ov = k; cap_data = out_data; end
            end
            if (err_valid && first_err < 0) begin first_err = k; seen_code = err_code; end
            if (k == rst_k) begin
                rst_n = 1'b0;
                @(negedge rng_clk);
                got = pk(apb.m_psel, apb.m_penable, apb.m_pwrite, apb.m_paddr, apb.m_pwdata,
                         busy, out_valid, err_valid, err_code);
                chk("reset_mid_read_outputs", got, 54'h0);
                chk("reset_mid_read_out_data", out_data, 128'h0);
                rst_n = 1'b1;
                fetch_req = 1'b0;
                out_ready = 1'b0;
                return;
            end
            fetch_req = (k < end_k) ? 1'($urandom_range(0, 1)) : chain;
            if (k >= t_out && k < t_out + d)  out_ready = 1'b0;
            else if (k == t_out + d)          out_ready = 1'b1;
            else                              out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        fetch_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge rng_clk);
            chk("idle_busy_psel", {busy, apb.m_psel}, 2'b00);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_n, t_err, t_b14, t_b15;
        logic [3:0] t_code;
        int nz, d;
        logic [3:0] last;
        bit chain;

        repeat (3) @(negedge rng_clk);
        chk("reset_outputs",
            pk(apb.m_psel, apb.m_penable, apb.m_pwrite, apb.m_paddr, apb.m_pwdata,
               busy, out_valid, err_valid, err_code), 54'h0);
        chk("reset_out_data", out_data, 128'h0);
        rst_n = 1'b1;
        @(negedge rng_clk);

        // Timeout: ISR never shows an event, poll limit 3, gap 4.
        fetch_req_t = 1'b1;
        t_n = 0; t_err = -1; t_b14 = -1; t_b15 = -1; t_code = 4'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge rng_clk);
            fetch_req_t = 1'b0;
            if (apb_t.m_psel && !apb_t.m_penable) t_n++;
            if (err_valid_t && t_err < 0) begin t_err = k; t_code = err_code_t; end
            if (k == 14) t_b14 = int'(busy_t);
            if (k == 15) t_b15 = int'(busy_t);
        end
        chk("timeout_isr_reads", t_n, 3);
        chk("timeout_err_cycle", t_err, 15);
        chk("timeout_err_code", t_code, 4'b1000);
        chk("timeout_busy_before", t_b14, 1);
        chk("timeout_busy_falls", t_b15, 0);

        // Plain fetch with the first poll ready.
        run_scn(0, 4'h1, 2, 1'b0, -1, 1'b1);
        chk("basic_out_valid_cycle", first_ov, 13);
        chk("basic_out_data", cap_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("basic_icr_wdata", icr_wd, 32'h1);
        chk("basic_ehr_reads", n_ehr, 4);
        idle(3);

        // ISR = 9: vn_err plus data-ready, error wins.
        run_scn(0, 4'h9, 0, 1'b0, -1, 1'b1);
        chk("err_cycle", first_err, 5);
        chk("err_code", seen_code, 4'b0100);
        chk("err_icr_wdata", icr_wd, 32'h9);
        chk("err_ehr_reads", n_ehr, 0);
        chk("err_out_valid_cycles", ov_cycles, 0);
        idle(2);

        // Three empty polls, then ready.
        run_scn(3, 4'h1, 0, 1'b0, -1, 1'b1);
        chk("gap_isr_reads", n_isr, 4);
        chk("gap_poll0", isr_k[0], 1);
        chk("gap_poll1", isr_k[1], 7);
        chk("gap_poll2", isr_k[2], 13);
        chk("gap_poll3", isr_k[3], 19);
        chk("gap_out_valid_cycle", first_ov, 31);
        idle(2);

        // Consumer stalls 10 cycles, then accepts with a new request pending.
        run_scn(0, 4'h1, 10, 1'b1, -1, 1'b1);
        chk("stall_out_valid_cycles", ov_cycles, 11);
        run_scn(1, 4'h1, 3, 1'b0, -1, 1'b0);
        idle(2);

        // Reset while reading EHR word 2, then a fresh fetch.
        run_scn(0, 4'h1, 0, 1'b0, 8, 1'b0);
        idle(2);
        run_scn(0, 4'h1, 1, 1'b0, -1, 1'b1);
        chk("after_reset_out_valid_cycle", first_ov, 13);
        chk("after_reset_out_data", cap_data, 128'h000000A3_000000A2_000000A1_000000A0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            nz    = $urandom_range(0, 3);
            last  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15)) : 4'h1;
            d     = $urandom_range(0, 6);
            chain = 1'($urandom_range(0, 1));
            run_scn(nz, last, d, chain, -1, 1'b0);
            if (!chain) idle($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
